// File: rtl/mac_tx_sched.sv
// Two-source round-robin frame scheduler in front of mac_tx/tx_fifo.
// Streams the granted frame into tx_fifo, starts mac_tx, then holds the IFG.
module mac_tx_sched #(
  parameter int IFG_BYTES = 12,
  parameter int MAX_LEN   = 1514,
  parameter int LEN_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  output logic             gnt0,
  output logic             gnt1,
  input  logic [7:0]       src0_data,
  input  logic [7:0]       src1_data,
  input  logic             src0_valid,
  input  logic             src1_valid,
  input  logic             src0_last,
  input  logic             src1_last,
  output logic             src0_ready,
  output logic             src1_ready,
  output logic             tx_fifo_wr_en,
  output logic [7:0]       tx_fifo_wr_data,
  input  logic             tx_fifo_full,
  output logic             tx_start,
  output logic [LEN_W-1:0] tx_len,
  input  logic             tx_done,
  output logic             frame_trunc,
  output logic             busy
);

  localparam int IFG_W =
    (IFG_BYTES > 0) ? $clog2(IFG_BYTES + 1) : 1;
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);
  localparam logic [IFG_W-1:0] IFG_CNT = IFG_W'(IFG_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_IFG
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_rr_last;
  logic [LEN_W-1:0] r_byte_cnt;
  logic             r_trunc;
  logic [IFG_W-1:0] r_ifg_cnt;
  logic             r_tx_start;
  logic [LEN_W-1:0] r_tx_len;
  logic             r_frame_trunc;
  logic             r_busy;

  logic             w_any_req;
  logic             w_pick1;
  logic             w_load;
  logic             w_room;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic             w_accept;
  logic             w_wr;
  logic             w_end;

  // Both requesting: the source not served last wins.
  assign w_any_req = req0 | req1;
  assign w_pick1   = req1 & (~req0 | ~r_rr_last);
  assign w_room    = r_byte_cnt < MAX_CNT;
  assign w_end     = w_accept & w_sel_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_LOAD;
      S_LOAD:  if (w_end) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          if (IFG_BYTES == 0) w_next = S_IDLE;
          else                w_next = S_IFG;
        end
      end
      S_IFG: begin
        if (r_ifg_cnt == IFG_W'(1)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Source handshake and fifo write path
  always_comb begin
    w_load      = r_state == S_LOAD;
    src0_ready  = r_gnt0 & w_load & ~tx_fifo_full;
    src1_ready  = r_gnt1 & w_load & ~tx_fifo_full;
    w_sel_valid = (r_gnt0 & src0_valid) |
                  (r_gnt1 & src1_valid);
    w_sel_last  = (r_gnt0 & src0_last) |
                  (r_gnt1 & src1_last);
    w_accept    = w_sel_valid & w_load &
                  ~tx_fifo_full;
    w_wr        = w_accept & w_room;
    tx_fifo_wr_en   = w_wr;
    tx_fifo_wr_data = 8'h00;
    if (r_gnt0)      tx_fifo_wr_data = src0_data;
    else if (r_gnt1) tx_fifo_wr_data = src1_data;
  end

  // Grant, byte counting, length capture and IFG timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_rr_last     <= 1'b1;
      r_byte_cnt    <= '0;
      r_trunc       <= 1'b0;
      r_ifg_cnt     <= '0;
      r_tx_start    <= 1'b0;
      r_tx_len      <= '0;
      r_frame_trunc <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_tx_start    <= 1'b0;
      r_frame_trunc <= 1'b0;
      r_busy        <= w_next != S_IDLE;
      unique case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt0     <= ~w_pick1;
            r_gnt1     <= w_pick1;
            r_rr_last  <= w_pick1;
            r_byte_cnt <= '0;
            r_trunc    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_wr) r_byte_cnt <= r_byte_cnt + LEN_W'(1);
          if (w_accept & ~w_room) r_trunc <= 1'b1;
          if (w_end) begin
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_tx_start    <= 1'b1;
            r_tx_len      <= w_wr ? r_byte_cnt + LEN_W'(1)
                                  : r_byte_cnt;
            r_frame_trunc <= r_trunc | ~w_room;
          end
        end
        S_WAIT: begin
          if (tx_done) r_ifg_cnt <= IFG_CNT;
        end
        S_IFG: r_ifg_cnt <= r_ifg_cnt - IFG_W'(1);
        default: ;
      endcase
    end
  end

  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign tx_start    = r_tx_start;
  assign tx_len      = r_tx_len;
  assign frame_trunc = r_frame_trunc;
  assign busy        = r_busy;

endmodule

// File: tb/tb_mac_tx_sched.sv
// Bench for mac_tx_sched: random frames against a frame-level model.
// MAX_LEN is shrunk to 24 so truncation is reachable alongside 20-byte frames.
module tb_mac_tx_sched;
  localparam int IFG  = 12;
  localparam int MAXL = 24;
  localparam int LW   = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic          gnt0, gnt1;
  logic [7:0]    src0_data, src1_data;
  logic          src0_valid, src1_valid;
  logic          src0_last, src1_last;
  logic          src0_ready, src1_ready;
  logic          tx_fifo_wr_en;
  logic [7:0]    tx_fifo_wr_data;
  logic          tx_fifo_full;
  logic          tx_start;
  logic [LW-1:0] tx_len;
  logic          tx_done;
  logic          frame_trunc;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_done = -1;
  bit rr_last = 1'b1;

  mac_tx_sched #(
    .IFG_BYTES(IFG), .MAX_LEN(MAXL), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .gnt0(gnt0), .gnt1(gnt1),
    .src0_data(src0_data), .src1_data(src1_data),
    .src0_valid(src0_valid), .src1_valid(src1_valid),
    .src0_last(src0_last), .src1_last(src1_last),
    .src0_ready(src0_ready), .src1_ready(src1_ready),
    .tx_fifo_wr_en(tx_fifo_wr_en),
    .tx_fifo_wr_data(tx_fifo_wr_data),
    .tx_fifo_full(tx_fifo_full),
    .tx_start(tx_start), .tx_len(tx_len),
    .tx_done(tx_done), .frame_trunc(frame_trunc),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive_src(input int s, input logic v,
                           input logic [7:0] d,
                           input logic l);
    if (s == 0) begin
      src0_valid = v; src0_data = d; src0_last = l;
    end else begin
      src1_valid = v; src1_data = d; src1_last = l;
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? src0_ready : src1_ready;
  endfunction

  task automatic wait_gnt(output bit got);
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = gnt0 | gnt1;
    end
    chk("grant_seen", 32'(got), 1);
  endtask

  // One whole frame: grant, byte stream, start, done.
  task automatic do_frame(input int len, input int fmode,
                          input bit gaps, input bit keep,
                          input bit strays);
    logic [7:0] fr [64];
    int win, idx, wr, n, elen;
    bit got;
    logic v, f, ew;
    for (int i = 0; i < len; i++) fr[i] = 8'($urandom);
    win = (req0 && req1) ? (rr_last ? 0 : 1)
                         : (req0 ? 0 : 1);
    elen = (len > MAXL) ? MAXL : len;
    wait_gnt(got);
    if (!got) return;
    chk("gnt0", 32'(gnt0), 32'(win == 0));
    chk("gnt1", 32'(gnt1), 32'(win == 1));
    chk("busy_load", 32'(busy), 1);
    if (last_done >= 0)
      chk("ifg_gap", cyc - last_done, IFG + 1);
    rr_last = win[0];
    if (!keep) begin
      if (win == 0) req0 = 1'b0;
      else          req1 = 1'b0;
    end
    idx = 0; wr = 0; n = 0;
    while (idx < len && n < 400) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (fmode == 1)      f = ($urandom_range(0, 3) == 0);
      else if (fmode == 2) f = (n >= 5 && n < 10);
      else                 f = 1'b0;
      drive_src(win, v, fr[idx], idx == len - 1);
      tx_fifo_full = f;
      if (strays) begin
        drive_src(1 - win, 1'($urandom_range(0, 1)),
                  8'($urandom), 1'($urandom_range(0, 1)));
        tx_done = 1'($urandom_range(0, 1));
      end
      #1;
      chk("ready", 32'(rdy(win)), 32'(!f));
      chk("ready_other", 32'(rdy(1 - win)), 0);
      ew = v && !f && (wr < MAXL);
      chk("wr_en", 32'(tx_fifo_wr_en), 32'(ew));
      if (ew)
        chk("wr_data", 32'(tx_fifo_wr_data), 32'(fr[idx]));
      if (v && !f) begin
        if (wr < MAXL) wr++;
        idx++;
      end
      n++;
      @(negedge clk);
    end
    chk("frame_complete", idx, len);
    drive_src(0, 1'b0, 8'h00, 1'b0);
    drive_src(1, 1'b0, 8'h00, 1'b0);
    tx_fifo_full = 1'b0;
    tx_done = 1'b0;
    #1;
    chk("tx_start", 32'(tx_start), 1);
    chk("gnt_clear", 32'({gnt1, gnt0}), 0);
    chk("tx_len", 32'(tx_len), elen);
    chk("frame_trunc", 32'(frame_trunc), 32'(len > MAXL));
    chk("wr_en_start", 32'(tx_fifo_wr_en), 0);
    chk("busy_start", 32'(busy), 1);
    @(negedge clk);
    chk("tx_start_1cyc", 32'(tx_start), 0);
    chk("trunc_1cyc", 32'(frame_trunc), 0);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    last_done = cyc;
    #1;
    chk("busy_ifg", 32'(busy), 1);
    chk("tx_len_hold", 32'(tx_len), elen);
    chk("gnt_ifg", 32'({gnt1, gnt0}), 0);
  endtask

  initial begin
    bit got;
    rst = 1'b1;
    req0 = 0; req1 = 0;
    drive_src(0, 1'b0, 8'h00, 1'b0);
    drive_src(1, 1'b0, 8'h00, 1'b0);
    tx_fifo_full = 0; tx_done = 0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'({gnt1, gnt0}), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_len", 32'(tx_len), 0);
    chk("rst_trunc", 32'(frame_trunc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'({src1_ready, src0_ready}), 0);
    chk("rst_wr_en", 32'(tx_fifo_wr_en), 0);
    chk("rst_wr_data", 32'(tx_fifo_wr_data), 0);
    rst = 1'b0;

    // stray tx_done in IDLE
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    chk("idle_done_busy", 32'(busy), 0);
    chk("idle_done_gnt", 32'({gnt1, gnt0}), 0);
    chk("idle_done_start", 32'(tx_start), 0);

    // round robin, both requests held
    req0 = 1; req1 = 1;
    for (int k = 0; k < 4; k++)
      do_frame($urandom_range(4, 20), 0, 0, 1, 0);

    // single 20-byte frame, no gaps
    req0 = 1; req1 = 0;
    do_frame(20, 0, 0, 0, 0);

    // 5-cycle full burst mid-frame
    req1 = 1;
    do_frame(20, 2, 0, 0, 0);

    // length boundaries
    req0 = 1;
    do_frame(MAXL, 0, 0, 0, 0);
    req1 = 1;
    do_frame(MAXL + 1, 0, 0, 0, 0);
    req0 = 1;
    do_frame(30, 1, 1, 0, 0);
    req1 = 1;
    do_frame(1, 0, 0, 0, 0);

    // stray valid / tx_done from outside
    req0 = 1;
    do_frame(12, 1, 1, 0, 1);

    // random traffic
    for (int k = 0; k < 16; k++) begin
      int r;
      r = $urandom_range(1, 3);
      req0 = r[0]; req1 = r[1];
      do_frame($urandom_range(1, 36),
               $urandom_range(0, 2),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end
    req0 = 0; req1 = 0;

    // reset mid-LOAD
    repeat (20) @(negedge clk);
    last_done = -1;
    req0 = 1;
    wait_gnt(got);
    for (int i = 0; i < 5; i++) begin
      drive_src(0, 1'b1, 8'(i + 1), 1'b0);
      #1;
      chk("pre_rst_wr", 32'(tx_fifo_wr_en), 1);
      @(negedge clk);
    end
    #3;
    rst = 1'b1;
    #1;
    chk("arst_gnt", 32'({gnt1, gnt0}), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(src0_ready), 0);
    chk("arst_wr_en", 32'(tx_fifo_wr_en), 0);
    chk("arst_wr_data", 32'(tx_fifo_wr_data), 0);
    chk("arst_tx_len", 32'(tx_len), 0);
    chk("arst_start", 32'(tx_start), 0);
    rr_last = 1'b1;
    @(negedge clk);
    drive_src(0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    req0 = 0; req1 = 1;
    do_frame(10, 0, 0, 0, 0);

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_tx_sched.md
# mac_tx_sched

Frame scheduler that sits in front of `mac_tx` and its `tx_fifo`. It shares the transmit path between two frame sources using round-robin arbitration, streams the granted source's bytes into `tx_fifo`, and pulses `init` to `mac_tx` with the frame length. It then waits for transmission to complete and enforces the inter-frame gap before granting again.

## Interface
Parameters:
- `IFG_BYTES`, 12: idle byte times enforced after `tx_done` before the next grant.
- `MAX_LEN`, 1514: maximum bytes written per frame; longer frames are truncated.
- `LEN_W`, 11: width of the length counter and `tx_len`.

Ports (clock and reset are one clock, asynchronous, active-high reset, as already decided):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: source n has a frame pending.
- `gnt0`, `gnt1` out 1: registered, one-hot or zero; source n owns the path.
- `src0_data`, `src1_data` in 8: frame byte (dest MAC, type, payload).
- `src0_valid`, `src1_valid` in 1: byte valid.
- `src0_last`, `src1_last` in 1: byte is final byte of frame.
- `src0_ready`, `src1_ready` out 1: combinational; `gntn & state==LOAD & !tx_fifo_full`.
- `tx_fifo_wr_en` out 1: combinational; write strobe to `tx_fifo`.
- `tx_fifo_wr_data` out 8: combinational mux of the granted `srcn_data`.
- `tx_fifo_full` in 1: `tx_fifo` full flag.
- `tx_start` out 1: registered one-cycle pulse; drives `mac_tx` `init`.
- `tx_len` out LEN_W: registered byte count of the frame; stable from `tx_start` until the next LOAD.
- `tx_done` in 1: one-cycle pulse from `mac_tx` when CRC is sent.
- `frame_trunc` out 1: registered one-cycle pulse when a frame was truncated.
- `busy` out 1: registered; high in every state except IDLE.

## Operation
- States: IDLE, LOAD, START, WAIT_DONE, IFG.
- **IDLE.**
  - If any `req`, grant one source and go to LOAD.
  - `rr_last` records the last-served source. With both requests, the source other than `rr_last` wins. With one request, that source wins.
  - `gnt` and `rr_last` update on the transition. `byte_cnt` clears to 0.
- **LOAD.**
  - A beat is accepted when `srcn_valid & srcn_ready` for the granted source.
  - On accept, while `byte_cnt < MAX_LEN`: `tx_fifo_wr_en=1`, data passes through, `byte_cnt` increments.
  - Once `byte_cnt == MAX_LEN`, accepted beats are discarded (`wr_en=0`, ready still follows `tx_fifo_full`) and the truncated flag is set.
  - Accepting a beat with `last` goes to START:
    - `tx_len` is loaded with the final count, including that byte if written.
    - `gnt` clears.
    - `frame_trunc` pulses if the frame was truncated.
- **START.** `tx_start=1` for exactly one cycle, then WAIT_DONE.
- **WAIT_DONE.** On `tx_done`, load `ifg_cnt=IFG_BYTES` and go to IFG. If `IFG_BYTES==0`, go directly to IDLE.
- **IFG.** `ifg_cnt` decrements each cycle. When `ifg_cnt==1`, go to IDLE.
- `tx_done` outside WAIT_DONE is ignored.
- `req` deassertion during LOAD is ignored; only `last` ends a frame.
- `valid` from the non-granted source is ignored; its `ready` is 0.
- The `byte_cnt` increment saturates at MAX_LEN; it never wraps.

## Timing
- Reset values:
  - `state=IDLE`.
  - `gnt0=gnt1=0`, `tx_start=0`, `tx_len=0`, `frame_trunc=0`, `busy=0`.
  - `rr_last=1`, so `req0` wins the first tie.
  - Combinational outputs are 0 in IDLE.
- Reset asserted mid-frame returns all state to reset values immediately. Bytes already in `tx_fifo` are not flushed; flushing is the system's job.
- `req` sampled at edge k in IDLE gives `gnt` high after edge k, and the first beat is acceptable in cycle k+1.
- `last` accepted at edge m gives `tx_start` high in cycle m+1 (after edge m) and `gnt` low from the same edge.
- `tx_done` at edge d gives IFG from d. The next grant is possible at the earliest at edge d+IFG_BYTES+1.
- `tx_fifo_full` high deasserts `ready` in the same cycle, with no write. Throughput is 1 byte/cycle when not full.

## Test plan
- Single frame: `req0`, 20 bytes, `last` on byte 20. Expect 20 `wr_en` pulses with matching data, `tx_len=20`, one `tx_start` the cycle after `last`, and `gnt0` low.
- Round-robin: `req0` and `req1` held high for 4 frames. Expect grant order 0,1,0,1, with each grant at least 13 cycles after the previous `tx_done` (IFG_BYTES=12).
- Backpressure: `tx_fifo_full` high for 5 cycles mid-frame. Expect `ready=0` and no `wr_en` during those cycles, with no byte lost or duplicated; `tx_len` is exact.
- Truncation: `MAX_LEN=16`, 20-byte frame. Expect 16 writes, `tx_len=16`, one `frame_trunc` pulse, and `tx_start` after byte 20 is accepted.
- Stray events: `tx_done` in IDLE or LOAD has no effect. `src1_valid` while `gnt0` produces no write and `src1_ready=0`.
- Reset mid-LOAD: assert `rst` after 5 bytes. All outputs go to 0 asynchronously. After release, `req1`-only is granted `gnt1` and the frame completes normally.
